csa_mult_pipe: RTL and testbench
================================

CSA_MULT_PIPE -- requirements
Module: csa_mult_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits (legal 4..64).
REQ-002 The block SHALL have parameter STAGES, default 4, meaning pipeline register stages (legal 1..WIDTH).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operand pair offered.
REQ-006 The block SHALL have port in_ready  output  1  operand pair accepted this cycle when high with in_valid.
REQ-007 The block SHALL have port a  input  WIDTH  multiplicand.
REQ-008 The block SHALL have port b  input  WIDTH  multiplier.
REQ-009 The block SHALL have port sign_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-010 The block SHALL have port out_valid  output  1  product present.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes product this cycle.
REQ-012 The block SHALL have port product  output  2*WIDTH  full-width product.
REQ-013 The block SHALL have port in_flight  output  $clog2(STAGES+1)  count of accepted, not yet delivered operations.

Function
REQ-014 The datapath SHALL be a carry-save partial-product array; the WIDTH partial-product rows SHALL be split evenly across STAGES, with remainder rows in the last stage, and final carry-propagate add in the last stage.
REQ-015 Transfer in: a, b, sign_mode SHALL be captured when in_valid && in_ready at a rising edge.
REQ-016 Advance condition: adv = !out_valid || out_ready; every stage register SHALL shift only when adv is high; the whole pipe stalls otherwise.
REQ-017 in_ready SHALL equal adv combinationally; no operation is dropped or duplicated under any out_ready pattern.
REQ-018 Latency SHALL be exactly STAGES cycles from accept edge to out_valid high when out_ready stays high; throughput one product per cycle.
REQ-019 product SHALL be held stable while out_valid && !out_ready.
REQ-020 product SHALL equal a*b mod 2^(2*WIDTH), unsigned or signed per the sampled sign_mode; each operation carries its own sign_mode through the pipe.
REQ-021 Each stage SHALL carry a valid bit; bubbles SHALL propagate as invalid and never raise out_valid.
REQ-022 in_flight SHALL increment on accept, decrement on delivery (out_valid && out_ready), remain unchanged when both occur in the same cycle; maximum value STAGES.
REQ-023 product SHALL read 0 whenever out_valid is low.

Reset
REQ-024 rst high SHALL asynchronously clear all stage valid bits, out_valid, product and in_flight to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL read 1 during reset and on the first edge after release.
REQ-026 Data registers other than valid bits need not be cleared, except the output register.

Configuration
REQ-027 Macro CSA_MULT_SIGNED_EN defined: sign_mode SHALL select two's-complement handling (Baugh-Wooley sign correction in the array).
REQ-028 Macro CSA_MULT_SIGNED_EN undefined: sign_mode SHALL be ignored, all operations unsigned, no sign-correction logic synthesised.

Verification
REQ-029 WIDTH=16, STAGES=4, out_ready=1: a=0,b=0 -> product=0 four cycles after accept.
REQ-030 WIDTH=16: a=14, b=65535, sign_mode=0 -> product=917490; a=3, b=3 -> product=9.
REQ-031 Signed build, WIDTH=16: a=16'hFFFF, b=16'hFFFF, sign_mode=1 -> product=1; same operands sign_mode=0 -> 4294836225; back-to-back in consecutive cycles, each result correct and in order.
REQ-032 Stream 6 ops, out_ready low for 3 cycles mid-stream -> in_ready falls with out_ready, product held, in_flight peaks at 4, all 6 results delivered in order.
REQ-033 Assert rst with 3 ops in flight -> out_valid and in_flight 0 immediately; no stale product appears after release.
REQ-034 Unsigned build: a=16'hFFFF, b=2, sign_mode=1 -> product=131070.

Source files
------------

// File: rtl/csa_mult_pipe.sv
// csa_mult_pipe -- pipelined carry-save array multiplier.
//
// Each operand pair is expanded into WIDTH partial-product rows. The rows are
// accumulated into a redundant (sum, carry) pair by 3:2 compressors. Every
// stage compresses WIDTH/STAGES rows. The last stage also compresses any
// remainder rows and then performs the single carry-propagate add that
// produces the registered product.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high on that side. The whole pipe advances only when the output register is
// empty or is being drained (adv = !out_valid || out_ready). Otherwise every
// stage holds. in_ready is adv, so an upstream offer is never lost or taken
// twice.
//
// Optional feature macro: CSA_MULT_SIGNED_EN
//   defined   : sign_mode = 1 multiplies two's-complement operands. The array
//               uses Baugh-Wooley sign correction for this.
//   undefined : sign_mode is ignored. Every operation is unsigned.
//
// Parameters
//   WIDTH      operand width in bits (4..64)
//   STAGES     number of pipeline register stages (1..WIDTH)
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair offered
//   in_ready   operand pair accepted this cycle when in_valid is also high
//   a, b       multiplicand, multiplier
//   sign_mode  1 = two's complement, 0 = unsigned (captured with a/b)
//   out_valid  product present
//   out_ready  consumer takes the product this cycle
//   product    full 2*WIDTH-bit product, forced to 0 while out_valid is low
//   in_flight  operations accepted but not yet delivered (0..STAGES)
module csa_mult_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         sign_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           product,
    output logic [$clog2(STAGES+1)-1:0]  in_flight
);

    localparam int P   = 2 * WIDTH;
    localparam int RPS = WIDTH / STAGES;   // rows per stage; the last stage also takes the remainder
    localparam int CW  = $clog2(STAGES + 1);

    // Stage registers. Index s holds the result of stage s. Only the valid
    // bits and the product register are reset.
    logic             v_r   [STAGES];
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] b_r   [STAGES];
    logic [P-1:0]     sum_r [STAGES];
    logic [P-1:0]     car_r [STAGES];
    logic [P-1:0]     prod_r;
    logic [CW-1:0]    cnt_r;

    // Combinational stage outputs.
    logic [P-1:0]     nsum  [STAGES];
    logic [P-1:0]     ncar  [STAGES];

    logic [WIDTH-1:0] ca, cb;
    logic [P-1:0]     cs, cc, pp, tsum;
    logic             pbit;
    int               pi;

    logic adv, acc, dlv;

`ifdef CSA_MULT_SIGNED_EN
    // Baugh-Wooley: each cross term with exactly one sign bit is inverted.
    // Inverting x gives ~x - 1. Together, the 2*(WIDTH-1) "-1" terms come to
    // 2^WIDTH - 2^(2W-1). Modulo 2^(2W), that is 2^WIDTH + 2^(2W-1). The pair
    // is preloaded into the carry vector.
    localparam logic [P-1:0] BW_K = (P'(1) << WIDTH) | (P'(1) << (P - 1));
    logic sg_r [STAGES];
    logic csg;
`else
    logic unused_sign;
    assign unused_sign = sign_mode;
`endif

    assign out_valid = v_r[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign dlv       = out_valid && out_ready;
    assign product   = out_valid ? prod_r : '0;
    assign in_flight = cnt_r;

    always_comb begin
        ca   = '0;
        cb   = '0;
        cs   = '0;
        cc   = '0;
        pp   = '0;
        tsum = '0;
        pbit = 1'b0;
        pi   = 0;
`ifdef CSA_MULT_SIGNED_EN
        csg  = 1'b0;
`endif
        for (int s = 0; s < STAGES; s++) begin
            pi = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
                ca = a;
                cb = b;
                cs = '0;
                cc = '0;
`ifdef CSA_MULT_SIGNED_EN
                csg = sign_mode;
                if (sign_mode)
                    cc = BW_K;
`endif
            end else begin
                ca = a_r[pi];
                cb = b_r[pi];
                cs = sum_r[pi];
                cc = car_r[pi];
`ifdef CSA_MULT_SIGNED_EN
                csg = sg_r[pi];
`endif
            end
            for (int r = 0; r < WIDTH; r++) begin
                if (r >= s * RPS && (s == STAGES - 1 || r < (s + 1) * RPS)) begin
                    pp = '0;
                    for (int j = 0; j < WIDTH; j++) begin
                        pbit = ca[j] & cb[r];
`ifdef CSA_MULT_SIGNED_EN
                        if (csg && ((r == WIDTH - 1) != (j == WIDTH - 1)))
                            pbit = ~pbit;
`endif
                        pp[r + j] = pbit;
                    end
                    // 3:2 compression; carries out of bit P-1 are dropped (mod 2^P).
                    tsum = cs ^ cc ^ pp;
                    cc   = ((cs & cc) | (cs & pp) | (cc & pp)) << 1;
                    cs   = tsum;
                end
            end
            nsum[s] = cs;
            ncar[s] = cc;
        end
    end

    // Control state: valid bits, output register, occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++)
                v_r[s] <= 1'b0;
            prod_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (adv) begin
                v_r[0] <= in_valid;
                for (int s = 1; s < STAGES; s++)
                    v_r[s] <= v_r[s-1];
                prod_r <= nsum[STAGES-1] + ncar[STAGES-1];
            end
            if (acc && !dlv)
                cnt_r <= cnt_r + CW'(1);
            else if (!acc && dlv)
                cnt_r <= cnt_r - CW'(1);
        end
    end

    // Datapath registers. Their contents are qualified by the valid bits, so
    // they need no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            a_r[0] <= a;
            b_r[0] <= b;
`ifdef CSA_MULT_SIGNED_EN
            sg_r[0] <= sign_mode;
`endif
            for (int s = 1; s < STAGES; s++) begin
                a_r[s] <= a_r[s-1];
                b_r[s] <= b_r[s-1];
`ifdef CSA_MULT_SIGNED_EN
                sg_r[s] <= sg_r[s-1];
`endif
            end
            for (int s = 0; s < STAGES; s++) begin
                sum_r[s] <= nsum[s];
                car_r[s] <= ncar[s];
            end
        end
    end

endmodule

// File: tb/tb_csa_mult_pipe.sv
// Testbench for csa_mult_pipe (WIDTH=16, STAGES=4).
// Expected products are hand-computed constants. The signed/unsigned choice
// follows CSA_MULT_SIGNED_EN.
module tb_csa_mult_pipe;

    localparam int W  = 16;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sign_mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic [2:0]    in_flight;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    logic [W-1:0]   op_a [8];
    logic [W-1:0]   op_b [8];
    logic           op_s [8];
    logic [2*W-1:0] op_p [8];

    csa_mult_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign_mode (sign_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .in_flight (in_flight)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sign_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (in_flight !== 3'd0) begin errors++; $display("FAIL reset_in_flight got %0d exp 0", in_flight); end
        checks++;
        if (product !== 32'd0) begin errors++; $display("FAIL reset_product got %0d exp 0", product); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
    endtask

    // One 0*0 operation. out_valid must rise after the 4th edge counting the accept edge.
    task automatic test_zero();
        in_valid  = 1'b1;
        a         = 16'd0;
        b         = 16'd0;
        sign_mode = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= ST + 1; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (k == 1) begin
                checks++;
                if (in_flight !== 3'd1) begin errors++; $display("FAIL zero_in_flight got %0d exp 1", in_flight); end
            end
            if (k < ST) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_early_valid edge %0d got %b exp 0", k, out_valid); end
            end else if (k == ST) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_latency got out_valid %b exp 1", out_valid); end
                checks++;
                if (product !== 32'd0) begin errors++; $display("FAIL zero_product got %0d exp 0", product); end
            end else begin
                checks++;
                if (out_valid !== 1'b0 || in_flight !== 3'd0) begin
                    errors++;
                    $display("FAIL zero_drain got out_valid %b in_flight %0d exp 0 0", out_valid, in_flight);
                end
            end
        end
    endtask

    // Eight operations streamed back to back with one bubble. out_ready stays high.
    task automatic test_back_to_back();
        int idx, got, cyc, ac;
        bit gap_done, acc, del;
        logic [2*W-1:0] exp_p;
        idx = 0; got = 0; cyc = 0; gap_done = 0;
        exp_q.delete();
        acc_q.delete();
        while (got < 8 && cyc < 60) begin
            out_ready = 1'b1;
            if (idx == 4 && !gap_done) begin
                in_valid = 1'b0;
                gap_done = 1'b1;
            end else if (idx < 8) begin
                in_valid  = 1'b1;
                a         = op_a[idx];
                b         = op_b[idx];
                sign_mode = op_s[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got product %0d exp no output", product);
                end else begin
                    exp_p = exp_q.pop_front();
                    ac    = acc_q.pop_front();
                    if (product !== exp_p) begin
                        errors++;
                        $display("FAIL b2b_product op %0d got %0d exp %0d", got, product, exp_p);
                    end
                    checks++;
                    if (cyc != ac + ST) begin
                        errors++;
                        $display("FAIL b2b_latency op %0d got %0d cycles exp %0d", got, cyc - ac, ST);
                    end
                    got++;
                end
            end
            if (acc) begin
                exp_q.push_back(op_p[idx]);
                acc_q.push_back(cyc);
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", got); end
    endtask

    // Six operations with out_ready held low for three cycles mid-stream.
    task automatic test_stall();
        int idx, got, cyc, cnt, peak;
        bit acc, del, prev_hold;
        logic [2*W-1:0] prev_prod, exp_p;
        idx = 0; got = 0; cyc = 0; cnt = 0; peak = 0;
        prev_hold = 1'b0;
        prev_prod = '0;
        exp_q.delete();
        while (got < 6 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (idx < 6) begin
                in_valid  = 1'b1;
                a         = op_a[idx];
                b         = op_b[idx];
                sign_mode = op_s[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL stall_in_ready cyc %0d got %b exp %b", cyc, in_ready, !out_valid || out_ready);
            end
            checks++;
            if (in_flight !== cnt[2:0]) begin
                errors++;
                $display("FAIL stall_in_flight cyc %0d got %0d exp %0d", cyc, in_flight, cnt);
            end
            if (in_flight > peak) peak = in_flight;
            if (prev_hold) begin
                checks++;
                if (product !== prev_prod) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d got %0d exp %0d", cyc, product, prev_prod);
                end
            end
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            prev_hold = out_valid && !out_ready;
            prev_prod = product;
            if (del) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_spurious got product %0d exp no output", product);
                end else begin
                    exp_p = exp_q.pop_front();
                    if (product !== exp_p) begin
                        errors++;
                        $display("FAIL stall_product op %0d got %0d exp %0d", got, product, exp_p);
                    end
                    got++;
                end
            end
            if (acc) begin
                exp_q.push_back(op_p[idx]);
                idx++;
            end
            cnt = cnt + int'(acc) - int'(del);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 6) begin errors++; $display("FAIL stall_count got %0d exp 6", got); end
        checks++;
        if (peak != ST) begin errors++; $display("FAIL stall_peak got %0d exp %0d", peak, ST); end
    endtask

    // Reset with three operations in flight, then one clean operation after release.
    task automatic test_reset_mid();
        int cyc;
        bit seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            a         = op_a[i];
            b         = op_b[i];
            sign_mode = op_s[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (in_flight !== 3'd3) begin errors++; $display("FAIL rstmid_pre_in_flight got %0d exp 3", in_flight); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
        checks++;
        if (in_flight !== 3'd0) begin errors++; $display("FAIL rstmid_in_flight got %0d exp 0", in_flight); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_in_ready got %b exp 1", in_ready); end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || product !== 32'd0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_stale got stale output exp none"); end
        // 3 * 3 after recovery
        in_valid  = 1'b1;
        a         = 16'd3;
        b         = 16'd3;
        sign_mode = 1'b0;
        cyc = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != ST) begin errors++; $display("FAIL rstmid_latency got %0d exp %0d", cyc, ST); end
        checks++;
        if (product !== 32'd9) begin errors++; $display("FAIL rstmid_product got %0d exp 9", product); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        op_a[0] = 16'd14;   op_b[0] = 16'hFFFF; op_s[0] = 1'b0; op_p[0] = 32'd917490;
        op_a[1] = 16'd3;    op_b[1] = 16'd3;    op_s[1] = 1'b0; op_p[1] = 32'd9;
        op_a[2] = 16'hFFFF; op_b[2] = 16'hFFFF; op_s[2] = 1'b1;
        op_a[3] = 16'hFFFF; op_b[3] = 16'hFFFF; op_s[3] = 1'b0; op_p[3] = 32'd4294836225;
        op_a[4] = 16'hFFFF; op_b[4] = 16'd2;    op_s[4] = 1'b1;
        op_a[5] = 16'h8000; op_b[5] = 16'h8000; op_s[5] = 1'b1; op_p[5] = 32'd1073741824;
        op_a[6] = 16'h8000; op_b[6] = 16'h7FFF; op_s[6] = 1'b1;
        op_a[7] = 16'h7FFF; op_b[7] = 16'h7FFF; op_s[7] = 1'b1; op_p[7] = 32'd1073676289;
`ifdef CSA_MULT_SIGNED_EN
        op_p[2] = 32'd1;            // -1 * -1
        op_p[4] = 32'd4294967294;   // -1 * 2 = -2
        op_p[6] = 32'd3221258240;   // -32768 * 32767
`else
        op_p[2] = 32'd4294836225;
        op_p[4] = 32'd131070;
        op_p[6] = 32'd1073709056;
`endif
        test_reset();
        @(posedge clk);
        #1;
        test_zero();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
